// File: rtl/rope_sim_pkg.sv
// rope_sim_pkg: shared types and constants for the rope/cloth Verlet sequencer.
package rope_sim_pkg;
    typedef enum logic [2:0] {IDLE, VERLET, PIN, SOLVE, WRITE, DONE} sched_state_t;
    localparam int BASE_X       = 200;
    localparam int NODE_SPACING = 10;
    localparam int STEP_CNT_W   = 16;
endpackage

// File: rtl/rope_step_scheduler_if.sv
// rope_step_scheduler_if: step trigger, solver handshake and node-array strobes.
interface rope_step_scheduler_if #(parameter int NUM_NODES = 8);
    import rope_sim_pkg::*;
    localparam int PAIR_W = $clog2(NUM_NODES);
    logic                  start;
    logic                  solve_ack;
    logic                  verlet_state;
    logic [NUM_NODES-1:0]  fix_en;
    logic                  anchor_sel;
    logic                  solve_req;
    logic [PAIR_W-1:0]     pair_idx;
    logic                  busy;
    logic                  done;
    logic [STEP_CNT_W-1:0] step_count;
    modport master (
        input  start, solve_ack,
        output verlet_state, fix_en, anchor_sel, solve_req, pair_idx, busy, done, step_count
    );
    modport slave (
        output start, solve_ack,
        input  verlet_state, fix_en, anchor_sel, solve_req, pair_idx, busy, done, step_count
    );
endinterface

// File: rtl/relax_iter_counter.sv
// relax_iter_counter: nested pair/sweep counter; pair wraps into the next sweep.
module relax_iter_counter #(
    parameter int NUM_NODES   = 8,
    parameter int RELAX_ITERS = 3,
    parameter int PAIR_W      = $clog2(NUM_NODES),
    parameter int ITER_W      = (RELAX_ITERS > 1) ? $clog2(RELAX_ITERS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              advance_i,
    output logic [PAIR_W-1:0] pair_o,
    output logic [ITER_W-1:0] iter_o,
    output logic              last_pair_o,
    output logic              last_iter_o
);
    logic [PAIR_W-1:0] pair_q, pair_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pair_q <= '0;
            iter_q <= '0;
        end else begin
            pair_q <= pair_d;
            iter_q <= iter_d;
        end
    end
    always_comb begin
        pair_d = clear_i ? '0 : advance_i ? (last_pair_o ? '0 : pair_q + 1'b1) : pair_q;
        iter_d = clear_i ? '0 : (advance_i && last_pair_o) ? (last_iter_o ? '0 : iter_q + 1'b1) : iter_q;
    end
    assign pair_o      = pair_q;
    assign iter_o      = iter_q;
    assign last_pair_o = pair_q == PAIR_W'(NUM_NODES - 2);
    assign last_iter_o = iter_q == ITER_W'(RELAX_ITERS - 1);
endmodule

// File: rtl/rope_step_scheduler.sv
// rope_step_scheduler: per-step Verlet pulse, optional anchor pin, then relaxation sweeps.
// Define ROPE_SCHED_PIN_EN to include the PIN state that re-pins node 0 each step.
module rope_step_scheduler
    import rope_sim_pkg::*;
#(
    parameter int NUM_NODES   = 8,
    parameter int RELAX_ITERS = 3,
    parameter int PAIR_W      = $clog2(NUM_NODES)
) (
    input logic                    clk,
    input logic                    reset,
    rope_step_scheduler_if.master  bus
);
    localparam int ITER_W = (RELAX_ITERS > 1) ? $clog2(RELAX_ITERS) : 1;
    sched_state_t          state_q, state_d;
    logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic [PAIR_W-1:0]     pair;
    logic [ITER_W-1:0]     iter;
    logic                  last_pair, last_iter;
    logic                  unused_iter;
    relax_iter_counter #(
        .NUM_NODES  (NUM_NODES),
        .RELAX_ITERS(RELAX_ITERS),
        .PAIR_W     (PAIR_W),
        .ITER_W     (ITER_W)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (state_q == VERLET),
        .advance_i  (state_q == WRITE),
        .pair_o     (pair),
        .iter_o     (iter),
        .last_pair_o(last_pair),
        .last_iter_o(last_iter)
    );
    assign unused_iter = ^iter;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.start ? VERLET : IDLE;
`ifdef ROPE_SCHED_PIN_EN
            VERLET:  state_d = PIN;
`else
            VERLET:  state_d = SOLVE;
`endif
            PIN:     state_d = SOLVE;
            SOLVE:   state_d = bus.solve_ack ? WRITE : SOLVE;
            WRITE:   state_d = (last_pair && last_iter) ? DONE : SOLVE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        step_cnt_d = (state_q == DONE) ? step_cnt_q + 1'b1 : step_cnt_q;
    end
    // Outputs decode straight from registered state, so an async reset clears them at once.
    assign bus.verlet_state = state_q == VERLET;
    assign bus.fix_en       = (state_q == WRITE) ? (NUM_NODES'(3) << pair) :
                              (state_q == PIN)   ? NUM_NODES'(1) : '0;
`ifdef ROPE_SCHED_PIN_EN
    assign bus.anchor_sel   = state_q == PIN;
`else
    assign bus.anchor_sel   = 1'b0;
`endif
    assign bus.solve_req    = state_q == SOLVE;
    assign bus.pair_idx     = pair;
    assign bus.busy         = state_q != IDLE;
    assign bus.done         = state_q == DONE;
    assign bus.step_count   = step_cnt_q;
endmodule

// File: tb/tb_rope_step_scheduler.sv
// tb_rope_step_scheduler: directed checks of step timing, handshake, start handling and reset.
module tb_rope_step_scheduler;
    import rope_sim_pkg::*;
    localparam int N = 8;
    localparam int R = 3;
`ifdef ROPE_SCHED_PIN_EN
    localparam int PO     = 0;
    localparam int PIN_ON = 1;
`else
    localparam int PO     = 1;
    localparam int PIN_ON = 0;
`endif
    localparam int D1 = 45 - PO;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    rope_step_scheduler_if #(.NUM_NODES(N)) bus ();
    rope_step_scheduler #(.NUM_NODES(N), .RELAX_ITERS(R)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );
    int checks = 0;
    int errors = 0;
    int cyc, verlet_at, pin_at, solve_at, idle_cnt, viol, anchor_cnt, extra;
    logic [7:0] first_wr, last_wr;
    int done_at[$];
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask
    task automatic do_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask
    // Called at #1 after a rising edge with the DUT idle; start is raised for that cycle (edge 0).
    task automatic run(input int lat, input int ndone, input bit hold, input int sp1,
                       input int sp2, input int abort_at, input int maxc);
        int w;
        bit preq, pack, aborted;
        logic [2:0] ppair;
        verlet_at = -1; pin_at = -1; solve_at = -1; idle_cnt = 0; viol = 0; anchor_cnt = 0;
        first_wr = '0; last_wr = '0; done_at.delete();
        w = 0; preq = 0; pack = 0; aborted = 0; ppair = '0;
        bus.start = 1'b1;
        bus.solve_ack = 1'b0;
        cyc = 0;
        while (done_at.size() < ndone && cyc < maxc && !aborted) begin
            @(posedge clk);
            #1;
            cyc++;
            bus.start = hold || cyc == sp1 || cyc == sp2;
            if (cyc == abort_at) begin
                chk("abort_pre_busy", {31'd0, bus.busy}, 1);
                reset = 1'b1;
                #1;
                chk("abort_outputs", {bus.verlet_state, bus.fix_en, bus.anchor_sel, bus.solve_req,
                                      bus.pair_idx, bus.busy, bus.done}, 0);
                chk("abort_step_count", {16'd0, bus.step_count}, 0);
                aborted = 1;
            end else begin
                if (bus.verlet_state && verlet_at < 0) verlet_at = cyc;
                if (bus.fix_en == 8'h01 && bus.anchor_sel && pin_at < 0) pin_at = cyc;
                if (bus.solve_req && solve_at < 0) solve_at = cyc;
                if (bus.anchor_sel) anchor_cnt++;
                if ($countones(bus.fix_en) == 2) begin
                    if (first_wr == '0) first_wr = bus.fix_en;
                    last_wr = bus.fix_en;
                end
                if ($countones(bus.fix_en) > 2 || (bus.verlet_state && bus.fix_en != '0)) viol++;
                if (preq && !pack && (!bus.solve_req || bus.pair_idx !== ppair)) viol++;
                if (!bus.busy && done_at.size() > 0) idle_cnt++;
                if (bus.done) done_at.push_back(cyc);
                preq = bus.solve_req;
                ppair = bus.pair_idx;
                w = bus.solve_req ? w + 1 : 0;
                bus.solve_ack = bus.solve_req && w == lat;
                pack = bus.solve_ack;
            end
        end
        bus.start = 1'b0;
        bus.solve_ack = 1'b0;
        if (!aborted && done_at.size() < ndone) chk("timeout_done_count", done_at.size(), ndone);
    endtask
    initial begin
        bus.start = 1'b0;
        bus.solve_ack = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_verlet", {31'd0, bus.verlet_state}, 0);
        chk("rst_fix_en", {24'd0, bus.fix_en}, 0);
        chk("rst_anchor", {31'd0, bus.anchor_sel}, 0);
        chk("rst_solve_req", {31'd0, bus.solve_req}, 0);
        chk("rst_pair_idx", {29'd0, bus.pair_idx}, 0);
        chk("rst_busy_done", {30'd0, bus.busy, bus.done}, 0);
        chk("rst_step_count", {16'd0, bus.step_count}, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        // Zero-wait solver
        run(1, 1, 0, -1, -1, -1, 200);
        chk("t1_verlet_at", verlet_at, 1);
        chk("t1_pin_at", pin_at, PIN_ON ? 2 : -1);
        chk("t1_anchor_cnt", anchor_cnt, PIN_ON);
        chk("t1_solve_at", solve_at, 3 - PO);
        chk("t1_first_write", {24'd0, first_wr}, 32'h03);
        chk("t1_last_write", {24'd0, last_wr}, 32'hC0);
        chk("t1_done_at", done_at[0], D1);
        chk("t1_violations", viol, 0);
        @(posedge clk);
        #1;
        chk("t1_step_count", {16'd0, bus.step_count}, 1);
        chk("t1_idle", {31'd0, bus.busy}, 0);
        // Solver waits 3 SOLVE cycles per pair
        do_reset();
        run(3, 1, 0, -1, -1, -1, 300);
        chk("t2_done_at", done_at[0], 87 - PO);
        chk("t2_solve_at", solve_at, 3 - PO);
        chk("t2_stability", viol, 0);
        @(posedge clk);
        #1;
        chk("t2_step_count", {16'd0, bus.step_count}, 1);
        // start pulses during a step are ignored
        do_reset();
        run(1, 1, 0, 5, 20, -1, 200);
        chk("t3_done_at", done_at[0], D1);
        extra = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) extra++;
        end
        chk("t3_no_second_step", extra, 0);
        chk("t3_step_count", {16'd0, bus.step_count}, 1);
        // start held high for three steps
        do_reset();
        run(1, 3, 1, -1, -1, -1, 500);
        chk("t4_done0", done_at[0], D1);
        chk("t4_done1", done_at[1], 2 * D1 + 1);
        chk("t4_done2", done_at[2], 3 * D1 + 2);
        chk("t4_idle_between", idle_cnt, 2);
        @(posedge clk);
        #1;
        chk("t4_step_count", {16'd0, bus.step_count}, 3);
        // Reset mid-step abandons the step and clears step_count
        run(1, 1, 0, -1, -1, 10, 200);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_idle_after", {30'd0, bus.busy, bus.done}, 0);
        run(1, 1, 0, -1, -1, -1, 200);
        chk("t5_done_at", done_at[0], D1);
        @(posedge clk);
        #1;
        chk("t5_step_count", {16'd0, bus.step_count}, 1);
        // step_count wraps from 0xFFFF to 0
        force dut.step_cnt_q = 16'hFFFF;
        #1;
        release dut.step_cnt_q;
        chk("t6_preload", {16'd0, bus.step_count}, 32'hFFFF);
        run(1, 1, 0, -1, -1, -1, 200);
        chk("t6_done_at", done_at[0], D1);
        chk("t6_anchor_cnt", anchor_cnt, PIN_ON);
        @(posedge clk);
        #1;
        chk("t6_wrap", {16'd0, bus.step_count}, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
